// File: rtl/vchannel_fifo_bank.sv
// vchannel_fifo_bank: four-way virtual-channel FIFO bank feeding the arbiter.
// Words are pushed by vc_id and popped by the arbiter's one-hot grant.
module vchannel_fifo_bank #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  push,
    input  logic [1:0]            vc_id,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [3:0]            valid_channel,
    output logic                  empty_vchannel0,
    output logic                  empty_vchannel1,
    output logic                  empty_vchannel2,
    output logic                  empty_vchannel3,
    output logic [3:0]            full_vchannel,
    output logic [3:0]            almost_full_vchannel,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [4][DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr [4];
    logic [ADDR_WIDTH-1:0] rd_ptr [4];
    logic [ADDR_WIDTH:0]   count  [4];

    logic [3:0] empty;
    logic       sel_any;
    logic       sel_onehot;
    logic       sel_multi;
    logic [1:0] pop_idx;
    logic       pop_ok;
    logic       pop_same;
    logic       push_req;
    logic       push_ok;
    logic       push_drop;
    logic [3:0] pop_vec;
    logic [3:0] push_vec;

    // Status flags decoded from the registered occupancy counts
    always_comb begin
        empty                = '0;
        full_vchannel        = '0;
        almost_full_vchannel = '0;
        for (int i = 0; i < 4; i++) begin
            empty[i]                = (count[i] == '0);
            full_vchannel[i]        = (count[i] == CNT_FULL);
            almost_full_vchannel[i] = (count[i] >= CNT_AF);
        end
    end

    assign empty_vchannel0 = empty[0];
    assign empty_vchannel1 = empty[1];
    assign empty_vchannel2 = empty[2];
    assign empty_vchannel3 = empty[3];

    // Grant legality check and one-hot to index encode
    always_comb begin
        sel_any    = |valid_channel;
        sel_onehot = sel_any &&
                     ((valid_channel & (valid_channel - 4'd1)) == 4'd0);
        sel_multi  = sel_any && !sel_onehot;
        pop_idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (valid_channel[i]) pop_idx = 2'(i);
        end
    end

    // Accept decisions; a full channel takes a push only while it is popped
    always_comb begin
        pop_ok    = enb && sel_onehot && !empty[pop_idx];
        pop_same  = pop_ok && (pop_idx == vc_id);
        push_req  = enb && push;
        push_ok   = push_req && (!full_vchannel[vc_id] || pop_same);
        push_drop = push_req && !push_ok;
        pop_vec   = pop_ok ? valid_channel : 4'd0;
        push_vec  = push_ok ? (4'd1 << vc_id) : 4'd0;
    end

    // Per-channel pointers and occupancy counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_vec[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop_vec[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                case ({push_vec[i], pop_vec[i]})
                    2'b10:   count[i] <= count[i] + CNT_ONE;
                    2'b01:   count[i] <= count[i] - CNT_ONE;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage array; contents are don't-care until counted as valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[vc_id][wr_ptr[vc_id]] <= data_in;
    end

    // Registered pop output and sticky protocol error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (pop_ok) data_out <= mem[pop_idx][rd_ptr[pop_idx]];
            if (push_drop || (enb && sel_multi)) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vchannel_fifo_bank.sv
// tb_vchannel_fifo_bank: directed and randomized checks of the FIFO bank
// against a queue-based reference model.
module tb_vchannel_fifo_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       push;
    logic [1:0] vc_id;
    logic [5:0] data_in;
    logic [3:0] valid_channel;
    logic       empty_vchannel0;
    logic       empty_vchannel1;
    logic       empty_vchannel2;
    logic       empty_vchannel3;
    logic [3:0] full_vchannel;
    logic [3:0] almost_full_vchannel;
    logic [5:0] data_out;
    logic       valid_out;
    logic       error;

    int n_tests = 0;
    int n_fails = 0;

    logic [5:0] mq [4][$];
    logic [5:0] m_data;
    logic       m_valid;
    logic       m_err;

    vchannel_fifo_bank #(
        .DATA_WIDTH(6),
        .ADDR_WIDTH(2),
        .AF_LEVEL(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .push(push),
        .vc_id(vc_id),
        .data_in(data_in),
        .valid_channel(valid_channel),
        .empty_vchannel0(empty_vchannel0),
        .empty_vchannel1(empty_vchannel1),
        .empty_vchannel2(empty_vchannel2),
        .empty_vchannel3(empty_vchannel3),
        .full_vchannel(full_vchannel),
        .almost_full_vchannel(almost_full_vchannel),
        .data_out(data_out),
        .valid_out(valid_out),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e_emp, e_full, e_af;
        for (int i = 0; i < 4; i++) begin
            e_emp[i]  = (mq[i].size() == 0);
            e_full[i] = (mq[i].size() == 4);
            e_af[i]   = (mq[i].size() >= 3);
        end
        chk({tag, ".empty"}, {28'd0, empty_vchannel3, empty_vchannel2,
                              empty_vchannel1, empty_vchannel0}, {28'd0, e_emp});
        chk({tag, ".full"}, {28'd0, full_vchannel}, {28'd0, e_full});
        chk({tag, ".afull"}, {28'd0, almost_full_vchannel}, {28'd0, e_af});
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, m_valid});
        chk({tag, ".data"}, {26'd0, data_out}, {26'd0, m_data});
        chk({tag, ".error"}, {31'd0, error}, {31'd0, m_err});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock of stimulus; the model decides from pre-edge queue contents.
    task automatic step(input string tag, input logic e, input logic p,
                        input logic [1:0] v, input logic [5:0] d,
                        input logic [3:0] s);
        int  ch;
        bit  popd;
        bit  pushd;
        int  ones;
        enb           = e;
        push          = p;
        vc_id         = v;
        data_in       = d;
        valid_channel = s;
        ch    = 0;
        popd  = 0;
        pushd = 0;
        ones  = $countones(s);
        for (int i = 0; i < 4; i++) if (s[i]) ch = i;
        if (e) begin
            if (ones == 1 && mq[ch].size() > 0) popd = 1;
            if (ones > 1) m_err = 1'b1;
            if (p) begin
                if (mq[v].size() < 4 || (popd && ch == int'(v))) pushd = 1;
                else m_err = 1'b1;
            end
            m_valid = popd;
            if (popd) m_data = mq[ch].pop_front();
            if (pushd) mq[v].push_back(d);
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst           = 1'b1;
        enb           = 1'b0;
        push          = 1'b0;
        vc_id         = 2'd0;
        data_in       = '0;
        valid_channel = 4'd0;
        model_reset();
        #3;
        check_all("reset");
        #4;
        rst = 1'b0;

        // Fill vc 2, then overflow it
        step("fill2a", 1, 1, 2'd2, 6'h11, 4'b0000);
        step("fill2b", 1, 1, 2'd2, 6'h12, 4'b0000);
        step("fill2c", 1, 1, 2'd2, 6'h13, 4'b0000);
        step("fill2d", 1, 1, 2'd2, 6'h14, 4'b0000);
        step("ovf2", 1, 1, 2'd2, 6'h15, 4'b0000);
        for (int i = 0; i < 4; i++) step("drain2", 1, 0, 2'd0, 6'h00, 4'b0100);
        step("idle", 1, 0, 2'd0, 6'h00, 4'b0000);

        // Wrap-around on vc 0 with interleaved pops
        step("wrap0", 1, 1, 2'd0, 6'h21, 4'b0000);
        step("wrap1", 1, 1, 2'd0, 6'h22, 4'b0000);
        step("wrap2", 1, 1, 2'd0, 6'h23, 4'b0001);
        step("wrap3", 1, 1, 2'd0, 6'h24, 4'b0001);
        step("wrap4", 1, 1, 2'd0, 6'h25, 4'b0001);
        step("wrap5", 1, 1, 2'd0, 6'h26, 4'b0000);
        for (int i = 0; i < 4; i++) step("wrapd", 1, 0, 2'd0, 6'h00, 4'b0001);
        step("wrape", 1, 0, 2'd0, 6'h00, 4'b0001);

        // Full vc 1 with same-edge push and pop
        step("f1a", 1, 1, 2'd1, 6'h31, 4'b0000);
        step("f1b", 1, 1, 2'd1, 6'h32, 4'b0000);
        step("f1c", 1, 1, 2'd1, 6'h33, 4'b0000);
        step("f1d", 1, 1, 2'd1, 6'h34, 4'b0000);
        step("f1pp", 1, 1, 2'd1, 6'h35, 4'b0010);

        // Empty vc 3 with same-edge push and pop
        step("e3pp", 1, 1, 2'd3, 6'h3a, 4'b1000);

        // Multi-bit grant with vc 1 and vc 2 non-empty
        step("v2in", 1, 1, 2'd2, 6'h2a, 4'b0000);
        step("multi", 1, 0, 2'd0, 6'h00, 4'b0110);

        // Disabled cycle with push and pop requested
        step("enb0", 0, 1, 2'd3, 6'h3f, 4'b1000);

        // Async reset between edges with 2 words in vc 0
        step("ar0", 1, 1, 2'd0, 6'h01, 4'b0000);
        step("ar1", 1, 1, 2'd0, 6'h02, 4'b0000);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("arst");
        #2;
        rst = 1'b0;
        step("arpop", 1, 0, 2'd0, 6'h00, 4'b0001);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [3:0] s;
            r = $urandom_range(0, 15);
            if (r < 4)       s = 4'd0;
            else if (r < 14) s = 4'd1 << (r % 4);
            else             s = 4'($urandom_range(0, 15));
            step("rand", ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                 6'($urandom), s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/vchannel_fifo_bank.md
# vchannel_fifo_bank

Four-way virtual-channel FIFO bank that buffers incoming words by virtual-channel ID and presents per-channel empty/full status. It sits directly upstream of the arbiter: its `empty_vchannel0..3` outputs drive the arbiter's inputs of the same name, and the arbiter's one-hot `valid_channel` grant comes back as the pop select. One popped word per cycle leaves on `data_out`/`valid_out` toward the downstream stage.

## Interface
- `DATA_WIDTH`, default 6: word width.
- `ADDR_WIDTH`, default 2: per-channel address width; depth per channel = 2**ADDR_WIDTH (4).
- `AF_LEVEL`, default 3: occupancy at or above which `almost_full_vchannel[n]` is asserted.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enb` in 1: global enable. When low there is no push and no pop.
- `push` in 1: write request.
- `vc_id` in 2: target channel for the push.
- `data_in` in DATA_WIDTH: word to write.
- `valid_channel` in 4: one-hot pop select (arbiter grant).
- `empty_vchannel0..3` out 1 each: channel n occupancy == 0.
- `full_vchannel` out 4: bit n set when occupancy of channel n == depth.
- `almost_full_vchannel` out 4: bit n set when occupancy of channel n >= AF_LEVEL.
- `data_out` out DATA_WIDTH: popped word, registered.
- `valid_out` out 1: `data_out` holds a word popped on the previous edge.
- `error` out 1: sticky protocol-error flag.

## Operation
- Each channel has write pointer, read pointer (ADDR_WIDTH bits, wrap modulo depth) and count (ADDR_WIDTH+1 bits, 0..depth).
- **Push accepted** when `enb & push & !full[vc_id]`: the word is written at wr_ptr[vc_id]; wr_ptr increments, wrapping 3→0.
- **Push to a full channel**: the word is dropped, pointers and count are unchanged, and `error` is set.
- **Pop select** is legal when `valid_channel` has exactly one bit set, or is 0000 (no pop).
  - Multiple bits set: no pop on any channel, and `error` is set.
- **Pop accepted** when `enb`, select is legal and non-zero, and the selected channel is non-empty:
  - `data_out` ← mem[sel][rd_ptr]; rd_ptr increments with wrap; `valid_out` ← 1.
- **Pop of an empty channel**: ignored, `valid_out` ← 0, no error. The arbiter can grant on a stale empty flag.
- **Simultaneous push and pop, same channel**:
  - Non-empty channel (including full): both occur, count unchanged. A push into a full channel is accepted if a pop of that channel happens on the same edge.
  - Empty channel: the push is accepted, the pop is ignored, count → 1.
- **Push and pop on different channels**: independent.
- **Cycles with no accepted pop**: `valid_out` ← 0; `data_out` holds its last value.
- **`enb` low**: all state holds, `valid_out` ← 0, `error` holds.
- **Status flags**: `empty`, `full` and `almost_full` are decoded combinationally from registered counts.
- **`error` clears only on `rst`.**

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - all pointers and counts 0;
  - `empty_vchannel0..3`=1, `full_vchannel`=0000, `almost_full_vchannel`=0000;
  - `data_out`=0, `valid_out`=0, `error`=0.
- Reset asserted mid-operation discards all stored words. The first push is accepted on the first rising edge after `rst` is low.
- Push latency: status flags reflect a push right after the edge that accepted it. `empty_vchannel[n]` falls in that cycle.
- Pop latency: one cycle. A grant sampled at edge k gives `data_out`/`valid_out` valid after edge k, and the flags update after the same edge.
- Throughput: one push and one pop per cycle.
- A channel filled by 4 back-to-back pushes shows `full` after the 4th edge. `almost_full` (AF_LEVEL=3) shows after the 3rd edge.

## Test plan
- Reset, then push 0x11,0x12,0x13,0x14 to vc 2 → `empty_vchannel2`=0 after the 1st edge, `almost_full[2]` after the 3rd, `full[2]` after the 4th, `error`=0.
- Push 0x15 to full vc 2 → dropped, `error`=1. Then pop vc 2 (0100) four times → `data_out` = 0x11,0x12,0x13,0x14 with `valid_out`=1, and `empty_vchannel2`=1 at the end.
- Wrap-around: push 6 words to vc 0 while popping 0001 interleaved → output order preserved, pointers pass 3→0, count never exceeds 4.
- Full vc 1 with push and pop of vc 1 on the same edge → push accepted, count stays 4, popped word is the oldest. Empty vc 3 with push and pop on the same edge → `valid_out`=0, count 1.
- `valid_channel`=0110 with vc 1 and vc 2 non-empty → no pop, `valid_out`=0, `error`=1. `enb`=0 with push and pop active → no state change.
- `rst` pulsed asynchronously between clock edges with 2 words stored in vc 0 → outputs go to reset values immediately, and the next pop 0001 gives `valid_out`=0.
